ps2_key_decoder: RTL and testbench

Sequencing controller for the 36-entry PS/2 scancode ROM (digits 0–9 at indices 0–9, letters A–Z at indices 10–35). It accepts raw scancode bytes from the PS/2 receiver, strips F0 break and E0 extended prefixes, and linearly searches the ROM for each make code. The matching index becomes an ASCII character. It also tracks the currently held key and counts distinct key presses for the display logic downstream.

---
 rtl/ps2_key_decoder.sv | 139 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ===========================================================================
// ps2_key_decoder: strips PS/2 prefixes, scans the scancode ROM, emits ASCII.
// Revision: 1.0
// ===========================================================================
module ps2_key_decoder #(
  parameter int ROM_DEPTH = 36,
  parameter int DIGITS    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       rom_r,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ascii,
  output logic       key_valid,
  output logic       key_down,
  output logic [7:0] key_count,
  output logic       miss,
  output logic       overrun
);

  localparam int            AW   = 6;
  localparam logic [AW-1:0] LAST = AW'(ROM_DEPTH - 1);
  localparam logic [AW-1:0] DIG  = AW'(DIGITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SKIP   = 2'd2,
    SEARCH = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [7:0]    code_reg, code_n;
  logic [7:0]    held_code, held_n;
  logic [7:0]    ascii_n, count_n;
  logic          down_n, kv_n, miss_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      code_reg  <= 8'h00;
      held_code <= 8'h00;
      ascii     <= 8'h00;
      key_count <= 8'h00;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
      miss      <= 1'b0;
      overrun   <= 1'b0;
      in_ready  <= 1'b1;
      rom_r     <= 1'b1;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      code_reg  <= code_n;
      held_code <= held_n;
      ascii     <= ascii_n;
      key_count <= count_n;
      key_down  <= down_n;
      key_valid <= kv_n;
      miss      <= miss_n;
      overrun   <= overrun | (in_valid & ~in_ready);
      // SKIP must still take its one discarded byte, so only SEARCH refuses input
      in_ready  <= (state_n != SEARCH);
      rom_r     <= (state_n != SEARCH);
    end
  end

  assign rom_addr = {2'b00, addr};

  always_comb begin
    state_n = state;
    addr_n  = addr;
    code_n  = code_reg;
    held_n  = held_code;
    ascii_n = ascii;
    count_n = key_count;
    down_n  = key_down;
    kv_n    = 1'b0;
    miss_n  = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_data == 8'hF0) begin
            state_n = BREAK;
          end else if (in_data == 8'hE0) begin
            state_n = SKIP;
          end else if (!(key_down && (in_data == held_code))) begin
            code_n  = in_data;
            addr_n  = '0;
            state_n = SEARCH;
          end
        end
      end
      BREAK: begin
        if (in_valid) begin
          if (key_down && (in_data == held_code)) begin
            down_n = 1'b0;
          end
          state_n = IDLE;
        end
      end
      SKIP: begin
        if (in_valid) begin
          state_n = IDLE;
        end
      end
      SEARCH: begin
        if (rom_data == code_reg) begin
          if (addr < DIG) begin
            ascii_n = 8'h30 + {2'b00, addr};
          end else begin
            ascii_n = 8'h41 + {2'b00, addr} - {2'b00, DIG};
          end
          kv_n    = 1'b1;
          held_n  = code_reg;
          down_n  = 1'b1;
          count_n = key_count + 8'd1;
          state_n = IDLE;
        end else if (addr == LAST) begin
          miss_n  = 1'b1;
          state_n = IDLE;
        end else begin
          addr_n = addr + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ===========================================================================
// tb_ps2_key_decoder: directed vector table plus hand sequences for the decoder.
// Revision: 1.0
// ===========================================================================
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       rom_r;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] ascii;
  logic       key_valid;
  logic       key_down;
  logic [7:0] key_count;
  logic       miss;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom [0:63];
  logic [7:0] exp_ascii;
  logic [7:0] exp_count;

  ps2_key_decoder #(.ROM_DEPTH(36), .DIGITS(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_r(rom_r), .rom_addr(rom_addr), .rom_data(rom_data),
    .ascii(ascii), .key_valid(key_valid), .key_down(key_down),
    .key_count(key_count), .miss(miss), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Combinational ROM; garbage while not enabled
  always_comb begin
    rom_data = 8'hAA;
    if (!rom_r) rom_data = rom[rom_addr[5:0]];
  end

  typedef struct {
    logic [7:0] code;
    logic       hit;
    logic [7:0] asc;
    int         cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Returns the cycle (acceptance = 0) in which key_valid or miss is seen
  task automatic press(input logic [7:0] code, output int cyc, output logic hit);
    send_byte(code);
    cyc = 1;
    while (!key_valid && !miss && cyc < 45) begin
      step();
      cyc++;
    end
    hit = key_valid;
  endtask

  task automatic release_key(input logic [7:0] code);
    send_byte(8'hF0);
    send_byte(code);
    chk("release key_down", key_down, 1'b0);
  endtask

  task automatic watch(input int n, output int kvs, output int misses, output int lows);
    kvs = 0; misses = 0; lows = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (key_valid) kvs++;
      if (miss) misses++;
      if (!rom_r) lows++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, kvs, misses, lows, walk_err, hit_err;
    logic       hit;
    logic [7:0] seq [36];

    seq = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
            8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
            8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    for (int i = 0; i < 64; i++) rom[i] = (i < 36) ? seq[i] : 8'h00;

    vecs[0] = '{code: 8'h45, hit: 1'b1, asc: 8'h30, cyc: 2};
    vecs[1] = '{code: 8'h46, hit: 1'b1, asc: 8'h39, cyc: 11};
    vecs[2] = '{code: 8'h1C, hit: 1'b1, asc: 8'h41, cyc: 12};
    vecs[3] = '{code: 8'h32, hit: 1'b1, asc: 8'h42, cyc: 13};
    vecs[4] = '{code: 8'h2D, hit: 1'b1, asc: 8'h52, cyc: 29};
    vecs[5] = '{code: 8'h1A, hit: 1'b1, asc: 8'h5A, cyc: 37};
    vecs[6] = '{code: 8'h5A, hit: 1'b0, asc: 8'h00, cyc: 37};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready", in_ready, 1'b1);
    chk("reset rom_r", rom_r, 1'b1);
    chk("reset rom_addr", rom_addr, 8'h00);
    chk("reset ascii", ascii, 8'h00);
    chk("reset flags", {key_valid, key_down, miss, overrun}, 4'b0000);
    chk("reset key_count", key_count, 8'h00);
    exp_ascii = 8'h00;
    exp_count = 8'h00;

    // First press: index 0, two-cycle latency
    send_byte(8'h45);
    chk("c1 rom_r", rom_r, 1'b0);
    chk("c1 in_ready", in_ready, 1'b0);
    step();
    chk("c2 rom_r", rom_r, 1'b1);
    chk("c2 key_valid", key_valid, 1'b1);
    chk("c2 ascii", ascii, 8'h30);
    chk("c2 key_down", key_down, 1'b1);
    chk("c2 key_count", key_count, 8'h01);
    chk("c2 in_ready", in_ready, 1'b1);
    exp_ascii = 8'h30; exp_count = 8'h01;
    release_key(8'h45);

    // Address walk for 'A'
    send_byte(8'h1C);
    walk_err = 0;
    for (int c = 1; c <= 11; c++) begin
      if (rom_addr != 8'(c - 1) || rom_r) walk_err++;
      step();
    end
    chk("walk addr errors", walk_err, 0);
    chk("walk c12 key_valid", key_valid, 1'b1);
    chk("walk c12 ascii", ascii, 8'h41);
    exp_ascii = 8'h41; exp_count++;
    release_key(8'h1C);
    chk("walk ascii held", ascii, 8'h41);

    for (int v = 0; v < 7; v++) begin
      press(vecs[v].code, cyc, hit);
      chk($sformatf("vec%0d cycle", v), cyc, vecs[v].cyc);
      chk($sformatf("vec%0d hit", v), hit, vecs[v].hit);
      if (vecs[v].hit) begin
        exp_ascii = vecs[v].asc;
        exp_count++;
      end
      chk($sformatf("vec%0d ascii", v), ascii, exp_ascii);
      chk($sformatf("vec%0d key_count", v), key_count, exp_count);
      chk($sformatf("vec%0d key_down", v), key_down, vecs[v].hit);
      step();
      chk($sformatf("vec%0d pulse", v), {key_valid, miss}, 2'b00);
      if (vecs[v].hit) release_key(vecs[v].code);
    end

    // Typematic repeats are dropped
    press(8'h32, cyc, hit);
    chk("typ first hit", hit, 1'b1);
    exp_count++;
    send_byte(8'h32);
    chk("typ repeat no search", rom_r, 1'b1);
    send_byte(8'h32);
    watch(40, kvs, misses, lows);
    chk("typ extra pulses", kvs + misses + lows, 0);
    chk("typ ascii", ascii, 8'h42);
    chk("typ key_count", key_count, exp_count);
    release_key(8'h32);

    // Byte offered during SEARCH is dropped and flagged
    chk("pre overrun", overrun, 1'b0);
    send_byte(8'h45);
    in_data = 8'h16; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovr key_valid", key_valid, 1'b1);
    chk("ovr ascii", ascii, 8'h30);
    chk("ovr flag", overrun, 1'b1);
    exp_count++;
    watch(40, kvs, misses, lows);
    chk("ovr lost byte", kvs + misses + lows, 0);
    chk("ovr sticky", overrun, 1'b1);
    release_key(8'h45);

    // Extended prefix discards the following byte
    send_byte(8'hE0);
    send_byte(8'h75);
    watch(40, kvs, misses, lows);
    chk("e0 no activity", kvs + misses + lows, 0);
    chk("e0 key_count", key_count, exp_count);
    press(8'h16, cyc, hit);
    chk("after e0 cycle", cyc, 3);
    chk("after e0 ascii", ascii, 8'h31);
    release_key(8'h16);

    // Reset in the middle of a search
    send_byte(8'h1C);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("rst rom_r", rom_r, 1'b1);
    chk("rst in_ready", in_ready, 1'b1);
    chk("rst rom_addr", rom_addr, 8'h00);
    chk("rst ascii", ascii, 8'h00);
    chk("rst flags", {key_valid, key_down, miss, overrun}, 4'b0000);
    chk("rst key_count", key_count, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    watch(40, kvs, misses, lows);
    chk("rst no pulses", kvs + misses + lows, 0);

    // 256 alternating presses wrap the counter
    hit_err = 0;
    for (int i = 0; i < 256; i++) begin
      press((i % 2 == 1) ? 8'h16 : 8'h45, cyc, hit);
      if (!hit) hit_err++;
      if (i == 254) chk("count 255", key_count, 8'hFF);
    end
    chk("wrap hits", hit_err, 0);
    chk("wrap key_count", key_count, 8'h00);
    chk("wrap ascii", ascii, 8'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
